hex_scan_driver: RTL and testbench

//   Time-multiplexed scan driver for an N-digit common-anode 7-segment display.

---
 rtl/hex_scan_driver_pkg.sv | 16 +
 rtl/scan_prescaler.sv | 42 ++++
 rtl/hex_scan_driver.sv | 111 +++++++++++
 tb/tb_hex_scan_driver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_driver_pkg.sv
// rtl/hex_scan_driver_pkg.sv - shared constants and helpers for the hex scan driver
package hex_scan_driver_pkg;

    // Default scan timing: clocks per digit slot and blanking gap at slot start
    localparam int DEF_SCAN_DIV  = 50000;
    localparam int DEF_BLANK_CYC = 500;

    // All digit enables off (active-low), wide enough for the largest legal display
    localparam logic [7:0] DIG_OFF = 8'hFF;

    // Counter width that stays at least one bit even for a range of one
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot cycle counter and digit index counter for the scan
module scan_prescaler
    import hex_scan_driver_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int CNT_W    = clog2_min1(SCAN_DIV),
    parameter int IDX_W    = clog2_min1(N_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fb,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_end;
    logic             w_idx_last;

    assign w_slot_end = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(N_DIGITS - 1));

    // Cycle counter wraps every slot; digit index advances at each slot end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign fb  = w_slot_end && w_idx_last;
    assign cnt = r_cnt;
    assign idx = r_idx;

endmodule

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - multiplexed N-digit hex display scan driver with frame-synchronous update
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  lz_blank,
    output logic [3:0]            D,
    output logic [N_DIGITS-1:0]   DIG,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int CNT_W = clog2_min1(SCAN_DIV);
    localparam int IDX_W = clog2_min1(N_DIGITS);

    logic                  w_fb;
    logic [CNT_W-1:0]      w_cnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_gap;
    logic [N_DIGITS-1:0]   w_zero_from;
    logic [3:0]            w_d;
    logic [N_DIGITS-1:0]   w_dig;

    logic [4*N_DIGITS-1:0] r_pend;
    logic [4*N_DIGITS-1:0] r_disp;
    logic                  r_pending;
    logic                  r_frame_tick;
    logic                  r_lz;

    scan_prescaler #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .fb  (w_fb),
        .cnt (w_cnt),
        .idx (w_idx)
    );

    // Double buffer: loads park in r_pend, the display copy changes only on the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else if (w_fb) begin
            if (load) begin
                r_disp    <= value;
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_disp    <= r_pend;
                r_pending <= 1'b0;
            end
        end else if (load) begin
            r_pend    <= value;
            r_pending <= 1'b1;
        end
    end

    // Frame tick marks slot 0 cycle 0; lz_blank is registered to keep inputs off the output path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_lz         <= 1'b0;
        end else begin
            r_frame_tick <= w_fb;
            r_lz         <= lz_blank;
        end
    end

    assign w_gap = (w_cnt < CNT_W'(BLANK_CYC));

    // w_zero_from[i] is set when every nibble at position i and above is zero
    always_comb begin
        w_zero_from = '0;
        w_zero_from[N_DIGITS-1] = (r_disp[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            w_zero_from[i] = w_zero_from[i+1] && (r_disp[4*i +: 4] == 4'h0);
        end
    end

    // Select the current nibble and enable at most one digit outside the gap
    always_comb begin
        w_d   = 4'h0;
        w_dig = DIG_OFF[N_DIGITS-1:0];
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_d = r_disp[4*i +: 4];
                if (!w_gap && !((i != 0) && r_lz && w_zero_from[i])) begin
                    w_dig[i] = 1'b0;
                end
            end
        end
    end

    assign D          = w_d;
    assign DIG        = w_dig;
    assign pending    = r_pending;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - self-checking bench for hex_scan_driver
module tb_hex_scan_driver;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [3:0]  D;
    logic [3:0]  DIG;
    logic        pending;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  obs_d   [FRAME];
    logic [3:0]  obs_dig [FRAME];
    logic        obs_pend[FRAME];

    always #5 clk = ~clk;

    hex_scan_driver #(
        .N_DIGITS  (N),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .D          (D),
        .DIG        (DIG),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    function automatic logic [3:0] exp_d(input logic [15:0] v, input int i);
        int s;
        s = i / SD;
        return v[4*s +: 4];
    endfunction

    function automatic logic [3:0] exp_dig(input logic [15:0] v, input bit lz, input int i);
        int s;
        int c;
        logic [3:0] one;
        s = i / SD;
        c = i % SD;
        one = 4'b0001;
        if (c < BC) return 4'hF;
        if (lz && s > 0 && (v >> (4 * s)) == 16'h0) return 4'hF;
        return ~(one << s);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic observe_frame();
        for (int i = 0; i < FRAME; i++) begin
            obs_d[i]    = D;
            obs_dig[i]  = DIG;
            obs_pend[i] = pending;
            @(negedge clk);
        end
    endtask

    task automatic drive_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        exp_q.delete();
        exp_q.push_back(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        int k_tick;
        logic [15:0] v;
        rst = 1'b1; load = 1'b0; value = 16'h0; lz_blank = 1'b0;
        step(2);
        n_cmp++; if (D !== 4'h0)     begin n_err++; $display("FAIL reset_D got %h want 0", D); end
        n_cmp++; if (DIG !== 4'hF)   begin n_err++; $display("FAIL reset_DIG got %b want 1111", DIG); end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        k_tick = -1;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step(1);
            if (frame_tick) begin k_tick = k; break; end
        end
        n_cmp++; if (k_tick != FRAME) begin n_err++; $display("FAIL reset_first_tick got %0d want %0d", k_tick, FRAME); end
        observe_frame();
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL reset_tick_period got %b want 1", frame_tick); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL reset_sb_empty got 0 want 1"); v = 16'h0; end
        else v = exp_q.pop_front();
        for (int i = 0; i < FRAME; i++) begin
            n_cmp++; if (obs_d[i] !== exp_d(v, i)) begin n_err++; $display("FAIL reset_frame_D cyc %0d got %h want %h", i, obs_d[i], exp_d(v, i)); end
            n_cmp++; if (obs_dig[i] !== exp_dig(v, 1'b0, i)) begin n_err++; $display("FAIL reset_frame_DIG cyc %0d got %b want %b", i, obs_dig[i], exp_dig(v, 1'b0, i)); end
        end
    endtask

    task automatic test_load();
        bit ok;
        logic [15:0] v;
        wait_frame(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL load_sync got timeout want tick"); end
        step(10);
        drive_load(16'h1234);
        n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL load_pending got %b want 1", pending); end
        ok = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (frame_tick) begin ok = 1'b1; break; end
            n_cmp++; if (D !== 4'h0) begin n_err++; $display("FAIL load_D_before_fb got %h want 0", D); end
            step(1);
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL load_fb got timeout want tick"); end
        observe_frame();
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL load_sb_empty got 0 want 1"); v = 16'h0; end
        else v = exp_q.pop_front();
        for (int i = 0; i < FRAME; i++) begin
            n_cmp++; if (obs_d[i] !== exp_d(v, i)) begin n_err++; $display("FAIL load_D cyc %0d got %h want %h", i, obs_d[i], exp_d(v, i)); end
            n_cmp++; if (obs_dig[i] !== exp_dig(v, 1'b0, i)) begin n_err++; $display("FAIL load_DIG cyc %0d got %b want %b", i, obs_dig[i], exp_dig(v, 1'b0, i)); end
            n_cmp++; if (obs_pend[i] !== 1'b0) begin n_err++; $display("FAIL load_pending_clear cyc %0d got %b want 0", i, obs_pend[i]); end
        end
    endtask

    task automatic test_lz_blank();
        bit ok;
        logic [15:0] v;
        lz_blank = 1'b1;
        for (int t = 0; t < 2; t++) begin
            wait_frame(ok);
            step(3);
            drive_load((t == 0) ? 16'h0050 : 16'h0000);
            wait_frame(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL lz_fb run %0d got timeout want tick", t); end
            observe_frame();
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL lz_sb_empty got 0 want 1"); v = 16'h0; end
            else v = exp_q.pop_front();
            for (int i = 0; i < FRAME; i++) begin
                n_cmp++; if (obs_d[i] !== exp_d(v, i)) begin n_err++; $display("FAIL lz_D val %h cyc %0d got %h want %h", v, i, obs_d[i], exp_d(v, i)); end
                n_cmp++; if (obs_dig[i] !== exp_dig(v, 1'b1, i)) begin n_err++; $display("FAIL lz_DIG val %h cyc %0d got %b want %b", v, i, obs_dig[i], exp_dig(v, 1'b1, i)); end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] v;
        wait_frame(ok);
        step(4);
        drive_load(16'hAAAA);
        step(6);
        drive_load(16'hBEEF);
        wait_frame(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_fb got timeout want tick"); end
        observe_frame();
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_sb_empty got 0 want 1"); v = 16'h0; end
        else v = exp_q.pop_front();
        for (int i = 0; i < FRAME; i++) begin
            n_cmp++; if (obs_d[i] !== exp_d(v, i)) begin n_err++; $display("FAIL b2b_D cyc %0d got %h want %h", i, obs_d[i], exp_d(v, i)); end
            n_cmp++; if (obs_dig[i] !== exp_dig(v, 1'b0, i)) begin n_err++; $display("FAIL b2b_DIG cyc %0d got %b want %b", i, obs_dig[i], exp_dig(v, 1'b0, i)); end
        end
    endtask

    task automatic test_fb_bypass();
        bit ok;
        logic [15:0] v;
        wait_frame(ok);
        step(5);
        drive_load(16'h1111);
        step(25);
        n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL bypass_pending_before got %b want 1", pending); end
        drive_load(16'h00FF);
        n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL bypass_tick got %b want 1", frame_tick); end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL bypass_pending_after got %b want 0", pending); end
        observe_frame();
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bypass_sb_empty got 0 want 1"); v = 16'h0; end
        else v = exp_q.pop_front();
        for (int i = 0; i < FRAME; i++) begin
            n_cmp++; if (obs_d[i] !== exp_d(v, i)) begin n_err++; $display("FAIL bypass_D cyc %0d got %h want %h", i, obs_d[i], exp_d(v, i)); end
            n_cmp++; if (obs_dig[i] !== exp_dig(v, 1'b0, i)) begin n_err++; $display("FAIL bypass_DIG cyc %0d got %b want %b", i, obs_dig[i], exp_dig(v, 1'b0, i)); end
            n_cmp++; if (obs_pend[i] !== 1'b0) begin n_err++; $display("FAIL bypass_pending cyc %0d got %b want 0", i, obs_pend[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k_tick;
        logic [15:0] v;
        wait_frame(ok);
        step(3);
        drive_load(16'h5678);
        wait_frame(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_fb got timeout want tick"); end
        step(4);
        drive_load(16'h9999);
        step(15);
        n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL rstmid_pending_before got %b want 1", pending); end
        n_cmp++; if (D !== 4'h6) begin n_err++; $display("FAIL rstmid_D_before got %h want 6", D); end
        n_cmp++; if (DIG !== 4'b1011) begin n_err++; $display("FAIL rstmid_DIG_before got %b want 1011", DIG); end
        rst = 1'b1;
        step(1);
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL rstmid_pending got %b want 0", pending); end
        n_cmp++; if (DIG !== 4'hF) begin n_err++; $display("FAIL rstmid_DIG got %b want 1111", DIG); end
        n_cmp++; if (D !== 4'h0) begin n_err++; $display("FAIL rstmid_D got %h want 0", D); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rstmid_tick got %b want 0", frame_tick); end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        k_tick = -1;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step(1);
            if (frame_tick) begin k_tick = k; break; end
        end
        n_cmp++; if (k_tick != FRAME) begin n_err++; $display("FAIL rstmid_first_tick got %0d want %0d", k_tick, FRAME); end
        observe_frame();
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rstmid_sb_empty got 0 want 1"); v = 16'h0; end
        else v = exp_q.pop_front();
        for (int i = 0; i < FRAME; i++) begin
            n_cmp++; if (obs_d[i] !== exp_d(v, i)) begin n_err++; $display("FAIL rstmid_D_frame cyc %0d got %h want %h", i, obs_d[i], exp_d(v, i)); end
            n_cmp++; if (obs_dig[i] !== exp_dig(v, 1'b0, i)) begin n_err++; $display("FAIL rstmid_DIG_frame cyc %0d got %b want %b", i, obs_dig[i], exp_dig(v, 1'b0, i)); end
            n_cmp++; if (obs_pend[i] !== 1'b0) begin n_err++; $display("FAIL rstmid_pending_frame cyc %0d got %b want 0", i, obs_pend[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_lz_blank();
        test_back_to_back();
        test_fb_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
